// File: rtl/bsg_mem_1r1w_sync_reader_if.sv
// Bundles the request, RAM read port and buffered output streams of the
// sync-RAM reader.
interface bsg_mem_1r1w_sync_reader_if #(
    parameter int width_p      = 8,
    parameter int addr_width_p = 4
);
    logic                    v_i;
    logic [addr_width_p-1:0] addr_i;
    logic                    ready_o;
    logic                    r_v_o;
    logic [addr_width_p-1:0] r_addr_o;
    logic [width_p-1:0]      r_data_i;
    logic                    v_o;
    logic [width_p-1:0]      data_o;
    logic                    yumi_i;

    modport slave (
        input  v_i, addr_i, r_data_i, yumi_i,
        output ready_o, r_v_o, r_addr_o, v_o, data_o
    );

    modport master (
        output v_i, addr_i, r_data_i, yumi_i,
        input  ready_o, r_v_o, r_addr_o, v_o, data_o
    );
endinterface

// File: rtl/bsg_mem_1r1w_sync_reader.sv
// Read-side front end for a 1r1w sync RAM: issues reads under a credit rule and
// buffers the one-cycle-late read data in a small FIFO for a valid/yumi consumer.
module bsg_mem_1r1w_sync_reader #(
    parameter int width_p   = -1,
    parameter int mem_els_p = -1,
    parameter int els_p     = 3
) (
    input logic clk_i,
    input logic reset_n_i,
    bsg_mem_1r1w_sync_reader_if.slave bus
);
    localparam int addr_width_lp = $clog2(mem_els_p);
    localparam int ptr_width_lp  = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int cnt_width_lp  = $clog2(els_p + 1);

    localparam logic [ptr_width_lp-1:0] lastPtr_lp  = ptr_width_lp'(els_p - 1);
    localparam logic [cnt_width_lp:0]   elsLimit_lp = (cnt_width_lp + 1)'(els_p);
    localparam logic [cnt_width_lp-1:0] fullCnt_lp  = cnt_width_lp'(els_p);

    logic                     inFlight_q, inFlight_d;
    logic [ptr_width_lp-1:0]  wrPtr_q, wrPtr_d;
    logic [ptr_width_lp-1:0]  rdPtr_q, rdPtr_d;
    logic [cnt_width_lp-1:0]  count_q, count_d;
    logic [width_p-1:0]       fifoMem [els_p];

    logic [cnt_width_lp:0]    occupancy;
    logic                     ready;
    logic                     issue;
    logic                     deq;
    logic [addr_width_lp-1:0] reqAddr;

    function automatic logic [ptr_width_lp-1:0] nextPtr(input logic [ptr_width_lp-1:0] p);
        return (p == lastPtr_lp) ? '0 : p + 1'b1;
    endfunction

    // Credits count both buffered words and the read still coming back from the RAM.
    always_comb begin
        occupancy  = {1'b0, count_q} + {{cnt_width_lp{1'b0}}, inFlight_q};
        ready      = reset_n_i & (occupancy < elsLimit_lp);
        issue      = bus.v_i & ready;
        deq        = bus.yumi_i & (count_q != '0);
        reqAddr    = bus.addr_i;
        inFlight_d = issue;
        wrPtr_d    = inFlight_q ? nextPtr(wrPtr_q) : wrPtr_q;
        rdPtr_d    = deq ? nextPtr(rdPtr_q) : rdPtr_q;
        count_d    = count_q + cnt_width_lp'(inFlight_q) - cnt_width_lp'(deq);
    end

    assign bus.ready_o  = ready;
    assign bus.r_v_o    = issue;
    assign bus.r_addr_o = reqAddr;
    assign bus.v_o      = (count_q != '0);
    assign bus.data_o   = fifoMem[rdPtr_q];

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            inFlight_q <= 1'b0;
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
        end else begin
            inFlight_q <= inFlight_d;
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            count_q    <= count_d;
        end
    end

    // Storage is left unreset; the pointers and count decide what is visible.
    always_ff @(posedge clk_i) begin
        if (inFlight_q) begin
            fifoMem[wrPtr_q] <= bus.r_data_i;
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk_i) begin
        if (reset_n_i) begin
            assert (!(bus.yumi_i && (count_q == '0)))
                else $error("yumi_i asserted while v_o is low");
            assert (!(inFlight_q && (count_q == fullCnt_lp)))
                else $error("read data captured into a full buffer");
        end
    end
`endif
endmodule

// File: tb/tb_bsg_mem_1r1w_sync_reader.sv
// Randomized bench for the sync-RAM reader; a queue of accepted reads is the reference.
module tb_bsg_mem_1r1w_sync_reader;
    localparam int WIDTH   = 16;
    localparam int MEMELS  = 32;
    localparam int AWIDTH  = 5;
    localparam int ELS     = 3;

    typedef struct {
        logic [WIDTH-1:0] data;
        int               cyc;
    } entry_t;

    logic clk;
    logic resetN;
    logic [WIDTH-1:0] ram [MEMELS];
    entry_t expQ [$];
    int cycle;
    int checkCount;
    int failCount;

    bsg_mem_1r1w_sync_reader_if #(.width_p(WIDTH), .addr_width_p(AWIDTH)) bus ();

    bsg_mem_1r1w_sync_reader #(
        .width_p(WIDTH),
        .mem_els_p(MEMELS),
        .els_p(ELS)
    ) dut (
        .clk_i(clk),
        .reset_n_i(resetN),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sync RAM: data appears the cycle after a read, garbage otherwise.
    always @(posedge clk) begin
        if (bus.r_v_o) bus.r_data_i <= ram[bus.r_addr_o];
        else           bus.r_data_i <= WIDTH'($urandom);
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, observed, expected, cycle);
        end
    endtask

    // One cycle: drive at the falling edge, check, then update the reference.
    // yumiMode: 0 never, 1 whenever valid, 2 random while valid.
    task automatic applyStimulus(input logic vReq, input int addr, input int yumiMode);
        logic vExp, readyExp, yumi, accept;
        @(negedge clk);
        vExp     = (expQ.size() > 0) && (expQ[0].cyc <= cycle - 2);
        readyExp = (expQ.size() < ELS);
        yumi     = vExp && ((yumiMode == 1) || ((yumiMode == 2) && ($urandom_range(0, 1) == 1)));
        accept   = vReq && readyExp;
        bus.v_i    = vReq;
        bus.addr_i = AWIDTH'(addr);
        bus.yumi_i = yumi;
        #1;
        checkOutput("ready_o", bus.ready_o, readyExp);
        checkOutput("v_o", bus.v_o, vExp);
        if (vExp) checkOutput("data_o", bus.data_o, expQ[0].data);
        checkOutput("r_v_o", bus.r_v_o, accept);
        if (accept) checkOutput("r_addr_o", bus.r_addr_o, addr);
        if (yumi) void'(expQ.pop_front());
        if (accept) expQ.push_back('{data: ram[addr], cyc: cycle});
        cycle++;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, 1);
    endtask

    initial begin
        checkCount = 0;
        failCount  = 0;
        cycle      = 0;
        for (int i = 0; i < MEMELS; i++) ram[i] = WIDTH'($urandom);
        ram[5] = 16'hA5A5;

        resetN     = 1'b0;
        bus.v_i    = 1'b1;
        bus.addr_i = 3;
        bus.yumi_i = 1'b0;
        #12;
        checkOutput("reset ready_o", bus.ready_o, 1'b0);
        checkOutput("reset v_o", bus.v_o, 1'b0);
        checkOutput("reset r_v_o", bus.r_v_o, 1'b0);
        bus.v_i = 1'b0;
        @(negedge clk);
        resetN = 1'b1;
        #1;
        checkOutput("post-reset ready_o", bus.ready_o, 1'b1);

        // Single read of the preloaded word.
        applyStimulus(1'b1, 5, 1);
        drain(4);

        // Back-to-back streaming with an eager consumer.
        for (int a = 0; a < 16; a++) applyStimulus(1'b1, a, 1);
        drain(4);

        // Backpressure: stall the consumer, release it for one cycle, stall again.
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 10 + i, 0);
        applyStimulus(1'b1, 20, 1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 21 + i, 0);
        drain(8);

        // Random traffic exercises pointer wrap in both directions.
        for (int i = 0; i < 300; i++)
            applyStimulus(1'($urandom_range(0, 1)), int'($urandom_range(0, MEMELS - 1)), 2);
        drain(8);

        // Reset while a read is in flight: its data must never surface.
        applyStimulus(1'b1, 7, 1);
        @(negedge clk);
        bus.v_i    = 1'b0;
        bus.yumi_i = 1'b0;
        resetN     = 1'b0;
        #1;
        checkOutput("midreset v_o", bus.v_o, 1'b0);
        checkOutput("midreset ready_o", bus.ready_o, 1'b0);
        checkOutput("midreset r_v_o", bus.r_v_o, 1'b0);
        expQ.delete();
        cycle++;
        @(negedge clk);
        resetN = 1'b1;
        #1;
        checkOutput("release ready_o", bus.ready_o, 1'b1);
        checkOutput("release v_o", bus.v_o, 1'b0);
        cycle++;
        drain(4);
        applyStimulus(1'b1, 9, 1);
        drain(4);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end
endmodule
